// File: rtl/gif_pkg.sv
// Shared types, widths and bank-address helpers for the GIF ping-pong frame sequencer.
package gif_pkg;

    localparam int unsigned WADDR_W = 8;
    localparam int unsigned RADDR_W = 10;
    localparam int unsigned WORD_W  = 128;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned WCNT_W  = WADDR_W - 1;
    localparam int unsigned PADDR_W = RADDR_W - 1;
    localparam int unsigned FCNT_W  = 16;
    localparam int unsigned DLY_W   = 8;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The back bank is always the one not being displayed.
    function automatic logic [WADDR_W-1:0] wr_addr(input logic front,
                                                   input logic [WCNT_W-1:0] wcnt);
        return {~front, wcnt};
    endfunction

    function automatic logic [RADDR_W-1:0] rd_addr(input logic front,
                                                   input logic [PADDR_W-1:0] pix_addr);
        return {front, pix_addr};
    endfunction

endpackage

// File: rtl/gif_delay_cnt.sv
// Counts display ticks since the last swap and decodes when the next frame is due.
module gif_delay_cnt
    import gif_pkg::*;
#(
    parameter int unsigned FRAME_DELAY = 6
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_frame_tick,
    input  logic i_clear,
    input  logic i_full,
    output logic o_due,
    output logic o_underrun_evt
);

    localparam int unsigned CMP_W = DLY_W + 1;

    logic [DLY_W-1:0] r_dly_cnt;
    logic             r_first;
    logic             w_elapsed;

    assign w_elapsed = (CMP_W'(r_dly_cnt) + CMP_W'(1)) >= CMP_W'(FRAME_DELAY);

    // Counter saturates at FRAME_DELAY-1 so a late frame swaps on the first tick after it fills.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dly_cnt <= '0;
            r_first   <= 1'b1;
        end else if (i_clear) begin
            r_dly_cnt <= '0;
            r_first   <= 1'b0;
        end else if (i_frame_tick) begin
            r_dly_cnt <= w_elapsed ? DLY_W'(FRAME_DELAY - 1) : r_dly_cnt + DLY_W'(1);
        end
    end

    assign o_due          = r_first | w_elapsed;
    assign o_underrun_evt = i_frame_tick & ~i_full & ~r_first & w_elapsed;

endmodule

// File: rtl/gif_frame_ctrl.sv
// Ping-pong frame sequencer: loads the back bank of img_ram and swaps banks on a due frame tick.
module gif_frame_ctrl
    import gif_pkg::*;
#(
    parameter int unsigned FRAME_DELAY    = 6,
    parameter int unsigned WORDS_PER_BANK = 128
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_in_valid,
    input  logic [WORD_W-1:0]  i_in_data,
    output logic               o_in_ready,
    input  logic               i_frame_tick,
    input  logic               i_pix_req,
    input  logic [PADDR_W-1:0] i_pix_addr,
    output logic [PIX_W-1:0]   o_pix_data,
    output logic               o_pix_valid,
    output logic [WORD_W-1:0]  o_dw,
    output logic [WADDR_W-1:0] o_addr_w,
    output logic               o_write,
    output logic               o_read,
    output logic [RADDR_W-1:0] o_addr_r,
    input  logic [PIX_W-1:0]   i_dr,
    output logic               o_front_bank,
    output logic [FCNT_W-1:0]  o_frame_count,
    output logic               o_underrun
);

    state_t              r_state;
    state_t              w_next_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_front_bank;
    logic [FCNT_W-1:0]   r_frame_count;
    logic                r_underrun;
    logic                r_pix_valid;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_last;
    logic                w_full;
    logic                w_due;
    logic                w_underrun_evt;
    logic                w_swap;

    assign w_full   = (r_state == HOLD);
    assign w_accept = i_in_valid & w_in_ready;
    assign w_last   = (r_wcnt == WCNT_W'(WORDS_PER_BANK - 1));
    assign w_swap   = i_frame_tick & w_full & w_due;

    gif_delay_cnt #(
        .FRAME_DELAY (FRAME_DELAY)
    ) u_delay (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_frame_tick   (i_frame_tick),
        .i_clear        (w_swap),
        .i_full         (w_full),
        .o_due          (w_due),
        .o_underrun_evt (w_underrun_evt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD: if (w_accept && w_last) w_next_state = HOLD;
            HOLD: if (w_swap)             w_next_state = LOAD;
            default:                      w_next_state = LOAD;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            LOAD:    w_in_ready = 1'b1;
            HOLD:    w_in_ready = 1'b0;
            default: w_in_ready = 1'b0;
        endcase
    end

    // Word counter, bank pointer, swap count, sticky underrun and read-valid pipe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wcnt        <= '0;
            r_front_bank  <= 1'b0;
            r_frame_count <= '0;
            r_underrun    <= 1'b0;
            r_pix_valid   <= 1'b0;
        end else begin
            if (w_swap) begin
                r_wcnt        <= '0;
                r_front_bank  <= ~r_front_bank;
                r_frame_count <= r_frame_count + FCNT_W'(1);
            end else if (w_accept) begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end
            r_pix_valid <= i_pix_req;
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_write       = w_accept;
    assign o_dw          = i_in_data;
    assign o_addr_w      = wr_addr(r_front_bank, r_wcnt);
    assign o_read        = i_pix_req;
    assign o_addr_r      = rd_addr(r_front_bank, i_pix_addr);
    assign o_pix_data    = i_dr;
    assign o_pix_valid   = r_pix_valid;
    assign o_front_bank  = r_front_bank;
    assign o_frame_count = r_frame_count;
    assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_gif_frame_ctrl.sv
// Self-checking bench for gif_frame_ctrl against a word-count/tick-count reference model.
module tb_gif_frame_ctrl;

    localparam int unsigned FD = 3;

    logic         i_clk;
    logic         i_reset;
    logic         i_in_valid;
    logic [127:0] i_in_data;
    logic         o_in_ready;
    logic         i_frame_tick;
    logic         i_pix_req;
    logic [8:0]   i_pix_addr;
    logic [7:0]   o_pix_data;
    logic         o_pix_valid;
    logic [127:0] o_dw;
    logic [7:0]   o_addr_w;
    logic         o_write;
    logic         o_read;
    logic [9:0]   o_addr_r;
    logic [7:0]   i_dr;
    logic         o_front_bank;
    logic [15:0]  o_frame_count;
    logic         o_underrun;

    gif_frame_ctrl #(
        .FRAME_DELAY    (FD),
        .WORDS_PER_BANK (128)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_in_valid    (i_in_valid),
        .i_in_data     (i_in_data),
        .o_in_ready    (o_in_ready),
        .i_frame_tick  (i_frame_tick),
        .i_pix_req     (i_pix_req),
        .i_pix_addr    (i_pix_addr),
        .o_pix_data    (o_pix_data),
        .o_pix_valid   (o_pix_valid),
        .o_dw          (o_dw),
        .o_addr_w      (o_addr_w),
        .o_write       (o_write),
        .o_read        (o_read),
        .o_addr_r      (o_addr_r),
        .i_dr          (i_dr),
        .o_front_bank  (o_front_bank),
        .o_frame_count (o_frame_count),
        .o_underrun    (o_underrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: words loaded into the back bank and ticks seen since the last swap.
    int m_words;
    bit m_front;
    bit m_first;
    int m_since;
    int m_count;
    bit m_underrun;
    bit m_pvalid;

    // Outputs sampled before the edge, with the model's expectation for that same cycle.
    logic         s_in_ready, s_write, s_read;
    logic [7:0]   s_addr_w, s_pix_data, s_dr;
    logic [9:0]   s_addr_r;
    logic [127:0] s_dw;
    logic         e_in_ready, e_write, e_read;
    logic [7:0]   e_addr_w;
    logic [9:0]   e_addr_r;

    task automatic model_reset();
        m_words = 0; m_front = 0; m_first = 1; m_since = 0;
        m_count = 0; m_underrun = 0; m_pvalid = 0;
    endtask

    task automatic step(input bit v, input logic [127:0] d, input bit t,
                        input bit r, input logic [8:0] pa);
        bit full, elapsed;
        logic [6:0] wlow;
        i_in_valid = v; i_in_data = d; i_frame_tick = t;
        i_pix_req = r; i_pix_addr = pa; i_dr = 8'($urandom);
        @(negedge i_clk);
        s_in_ready = o_in_ready; s_write = o_write; s_addr_w = o_addr_w; s_dw = o_dw;
        s_read = o_read; s_addr_r = o_addr_r; s_pix_data = o_pix_data; s_dr = i_dr;
        wlow       = 7'(m_words);
        e_in_ready = (m_words < 128);
        e_write    = v && e_in_ready;
        e_addr_w   = {~m_front, wlow};
        e_read     = r;
        e_addr_r   = {m_front, pa};
        if (t) begin
            full    = (m_words == 128);
            elapsed = (m_since + 1 >= int'(FD));
            if (full && (m_first || elapsed)) begin
                m_front = ~m_front; m_words = 0; m_since = 0; m_first = 0;
                m_count = (m_count + 1) % 65536;
            end else begin
                m_since++;
                if (!full && !m_first && elapsed) m_underrun = 1;
            end
        end
        if (e_write) m_words++;
        m_pvalid = r;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_reset = 1; i_in_valid = 0; i_in_data = '0; i_frame_tick = 0;
        i_pix_req = 0; i_pix_addr = '0; i_dr = '0;
        repeat (2) @(posedge i_clk);
        #1;
        model_reset();
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h exp=1", o_in_ready); end
        total++; if (o_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%0h exp=0", o_write); end
        total++; if (o_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%0h exp=0", o_read); end
        total++; if (o_pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix_valid got=%0h exp=0", o_pix_valid); end
        total++; if (o_front_bank !== 1'b0) begin bad++; $display("FAIL reset_front_bank got=%0h exp=0", o_front_bank); end
        total++; if (o_frame_count !== 16'h0) begin bad++; $display("FAIL reset_frame_count got=%0h exp=0", o_frame_count); end
        total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%0h exp=0", o_underrun); end
        total++; if (o_addr_w !== 8'h80) begin bad++; $display("FAIL reset_addr_w got=%0h exp=80", o_addr_w); end
        i_reset = 0;
    endtask

    task automatic test_initial_load();
        for (int i = 0; i < 128; i++) begin
            step(1, 128'(i), 0, 0, '0);
            total++; if (s_write !== 1'b1) begin bad++; $display("FAIL load_write[%0d] got=%0h exp=1", i, s_write); end
            total++; if (s_addr_w !== 8'(8'h80 + i)) begin bad++; $display("FAIL load_addr_w[%0d] got=%0h exp=%0h", i, s_addr_w, 8'(8'h80 + i)); end
            total++; if (s_dw !== 128'(i)) begin bad++; $display("FAIL load_dw[%0d] got=%0h exp=%0h", i, s_dw, i); end
        end
        step(1, 128'hdead, 0, 0, '0);
        total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL load_ready_drop got=%0h exp=0", s_in_ready); end
        total++; if (s_write !== 1'b0) begin bad++; $display("FAIL load_no_extra_write got=%0h exp=0", s_write); end
        step(0, '0, 1, 0, '0);
        total++; if (o_front_bank !== 1'b1) begin bad++; $display("FAIL first_swap_bank got=%0h exp=1", o_front_bank); end
        total++; if (o_frame_count !== 16'd1) begin bad++; $display("FAIL first_swap_count got=%0h exp=1", o_frame_count); end
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL first_swap_ready got=%0h exp=1", o_in_ready); end
    endtask

    task automatic test_read_map();
        step(0, '0, 0, 1, 9'h005);
        total++; if (s_read !== 1'b1) begin bad++; $display("FAIL rd_read got=%0h exp=1", s_read); end
        total++; if (s_addr_r !== 10'h205) begin bad++; $display("FAIL rd_addr_r got=%0h exp=205", s_addr_r); end
        total++; if (o_pix_valid !== 1'b1) begin bad++; $display("FAIL rd_pix_valid got=%0h exp=1", o_pix_valid); end
        i_pix_req = 0; i_dr = 8'hA5; #1;
        total++; if (o_pix_data !== 8'hA5) begin bad++; $display("FAIL rd_pix_data got=%0h exp=a5", o_pix_data); end
        step(0, '0, 0, 0, '0);
        total++; if (o_pix_valid !== 1'b0) begin bad++; $display("FAIL rd_pix_valid_drop got=%0h exp=0", o_pix_valid); end
    endtask

    task automatic test_delay();
        for (int i = 0; i < 128; i++) begin
            step(1, 128'($urandom), 0, 0, '0);
            total++; if (s_addr_w !== e_addr_w) begin bad++; $display("FAIL dly_addr_w[%0d] got=%0h exp=%0h", i, s_addr_w, e_addr_w); end
        end
        for (int k = 1; k <= 3; k++) begin
            step(0, '0, 1, 0, '0);
            repeat (2) step(0, '0, 0, 0, '0);
            total++; if (o_front_bank !== ((k < 3) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL dly_tick%0d_bank got=%0h exp=%0h", k, o_front_bank, (k < 3) ? 1'b1 : 1'b0); end
            total++; if (o_frame_count !== 16'(m_count)) begin bad++; $display("FAIL dly_tick%0d_count got=%0h exp=%0h", k, o_frame_count, m_count); end
        end
    endtask

    task automatic test_underrun();
        for (int k = 1; k <= 3; k++) begin
            step(0, '0, 1, 0, '0);
            total++; if (o_underrun !== ((k == 3) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL ur_tick%0d_flag got=%0h exp=%0h", k, o_underrun, (k == 3) ? 1'b1 : 1'b0); end
            total++; if (o_front_bank !== 1'b0) begin bad++; $display("FAIL ur_tick%0d_bank got=%0h exp=0", k, o_front_bank); end
        end
        for (int i = 0; i < 128; i++) step(1, 128'(i), 0, 0, '0);
        step(0, '0, 1, 0, '0);
        total++; if (o_front_bank !== 1'b1) begin bad++; $display("FAIL ur_late_swap got=%0h exp=1", o_front_bank); end
        total++; if (o_underrun !== 1'b1) begin bad++; $display("FAIL ur_sticky got=%0h exp=1", o_underrun); end
    endtask

    task automatic test_corner();
        for (int i = 0; i < 127; i++) step(1, 128'(i), (i % 10 == 9), 0, '0);
        step(1, 128'd127, 1, 0, '0);
        total++; if (s_write !== 1'b1) begin bad++; $display("FAIL cr_last_write got=%0h exp=1", s_write); end
        total++; if (o_front_bank !== 1'b1) begin bad++; $display("FAIL cr_no_swap got=%0h exp=1", o_front_bank); end
        step(0, '0, 1, 1, 9'h010);
        total++; if (s_addr_r !== 10'h210) begin bad++; $display("FAIL cr_swap_cycle_read got=%0h exp=210", s_addr_r); end
        total++; if (o_front_bank !== 1'b0) begin bad++; $display("FAIL cr_next_tick_swap got=%0h exp=0", o_front_bank); end
        total++; if (o_frame_count !== 16'(m_count)) begin bad++; $display("FAIL cr_count got=%0h exp=%0h", o_frame_count, m_count); end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 50; i++) step(1, 128'(i), 0, 0, '0);
        test_reset();
        step(1, 128'h77, 0, 0, '0);
        total++; if (s_addr_w !== 8'h80) begin bad++; $display("FAIL rst_mid_addr_w got=%0h exp=80", s_addr_w); end
        total++; if (s_write !== 1'b1) begin bad++; $display("FAIL rst_mid_write got=%0h exp=1", s_write); end
    endtask

    task automatic test_random();
        bit v, t, r;
        logic [127:0] d;
        logic [8:0] pa;
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            t  = ($urandom_range(0, 24) == 0);
            r  = $urandom_range(0, 1) == 1;
            d  = {$urandom, $urandom, $urandom, $urandom};
            pa = 9'($urandom);
            step(v, d, t, r, pa);
            total++; if (s_in_ready !== e_in_ready) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%0h exp=%0h", c, s_in_ready, e_in_ready); end
            total++; if (s_write !== e_write) begin bad++; $display("FAIL rnd_write c=%0d got=%0h exp=%0h", c, s_write, e_write); end
            if (e_write) begin
                total++; if (s_addr_w !== e_addr_w) begin bad++; $display("FAIL rnd_addr_w c=%0d got=%0h exp=%0h", c, s_addr_w, e_addr_w); end
                total++; if (s_dw !== d) begin bad++; $display("FAIL rnd_dw c=%0d got=%0h exp=%0h", c, s_dw, d); end
            end
            total++; if (s_read !== e_read) begin bad++; $display("FAIL rnd_read c=%0d got=%0h exp=%0h", c, s_read, e_read); end
            total++; if (s_addr_r !== e_addr_r) begin bad++; $display("FAIL rnd_addr_r c=%0d got=%0h exp=%0h", c, s_addr_r, e_addr_r); end
            total++; if (s_pix_data !== s_dr) begin bad++; $display("FAIL rnd_pix_data c=%0d got=%0h exp=%0h", c, s_pix_data, s_dr); end
            total++; if (o_pix_valid !== m_pvalid) begin bad++; $display("FAIL rnd_pix_valid c=%0d got=%0h exp=%0h", c, o_pix_valid, m_pvalid); end
            total++; if (o_front_bank !== m_front) begin bad++; $display("FAIL rnd_front_bank c=%0d got=%0h exp=%0h", c, o_front_bank, m_front); end
            total++; if (o_frame_count !== 16'(m_count)) begin bad++; $display("FAIL rnd_frame_count c=%0d got=%0h exp=%0h", c, o_frame_count, m_count); end
            total++; if (o_underrun !== m_underrun) begin bad++; $display("FAIL rnd_underrun c=%0d got=%0h exp=%0h", c, o_underrun, m_underrun); end
        end
    endtask

    initial begin
        test_reset();
        test_initial_load();
        test_read_map();
        test_delay();
        test_underrun();
        test_corner();
        test_reset_midload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gif_frame_ctrl.md
# gif_frame_ctrl

Ping-pong frame sequencer for `img_ram` in the play_gif project. It splits the RAM into two banks. It streams 128-bit frame words from the upstream decoder/flash reader into the back bank and maps display pixel reads onto the front bank. It swaps banks only on a display frame tick, once the back bank is full and the GIF frame delay has elapsed. It sits between the frame source, the VGA pixel fetch and the `img_ram` ports.

## Interface

- `FRAME_DELAY`, default 6: display frame ticks each GIF frame is shown, legal range 1..255.
- `WORDS_PER_BANK`, default 128: write words per bank. Fixed by `addr_w` width; the half-bank split is 128.
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream word valid.
- `in_data` in 128: upstream frame word.
- `in_ready` out 1: block accepts word this cycle.
- `frame_tick` in 1: one-cycle pulse at display vsync.
- `pix_req` in 1: display pixel read request.
- `pix_addr` in 9: pixel byte address within a bank.
- `pix_data` out 8: pixel byte.
- `pix_valid` out 1: `pix_data` valid.
- `dw` out 128: img_ram write data.
- `addr_w` out 8: img_ram write address, `{back_bank, word[6:0]}`.
- `write` out 1: img_ram write strobe.
- `read` out 1: img_ram read strobe.
- `addr_r` out 10: img_ram read address, `{front_bank, pix_addr}`.
- `dr` in 8: img_ram read data, valid one clock after `read`.
- `front_bank` out 1: bank currently displayed.
- `frame_count` out 16: number of swaps since reset.
- `underrun` out 1: sticky flag; a frame was due but the back bank was not full.

## Operation

- FSM states:
  - `LOAD`: `in_ready`=1. Each `in_valid&in_ready` writes one word and increments `wcnt`. Accepting word 127 sets `full` and moves to `HOLD`.
  - `HOLD`: `in_ready`=0. Waits for the swap condition.
- Swap condition, evaluated on a cycle with `frame_tick`=1: `full && (first || dly_cnt+1 >= FRAME_DELAY)`.
- On swap:
  - `front_bank` toggles.
  - `full`, `wcnt`, `dly_cnt` and `first` clear.
  - `frame_count` increments (wraps at 2^16).
  - State returns to `LOAD`, which now targets the old front bank.
- On `frame_tick` without a swap: `dly_cnt` increments, saturating at `FRAME_DELAY-1`.
- Underrun: if `frame_tick` occurs with `dly_cnt+1 >= FRAME_DELAY`, `!full` and `!first`, set `underrun`. It clears only on reset. The current frame stays displayed and the swap happens on the first tick after `full`.
- `first`: set by reset. The first loaded frame is displayed at the first tick after it is full, regardless of delay.
- Write path is combinational:
  - `write = in_valid & in_ready`
  - `dw = in_data`
  - `addr_w = {~front_bank, wcnt}`
- Read path:
  - `read = pix_req`
  - `addr_r = {front_bank, pix_addr}`
  - `pix_valid` is `pix_req` delayed one clock.
  - `pix_data = dr`

## Timing

- Reset values:
  - state `LOAD`, `front_bank`=0 (load targets bank 1), `wcnt`=0, `full`=0, `dly_cnt`=0, `first`=1
  - `frame_count`=0, `underrun`=0
  - `pix_valid`=0, `in_ready`=1, `write`=0, `read`=0
- Read latency: exactly 1 clock from `pix_req` to `pix_valid`, no back-pressure.
- Swap timing: `front_bank` changes at the clock edge ending the `frame_tick` cycle. A `pix_req` in that same cycle uses the old bank.
- Last word and `frame_tick` in the same cycle: `full` is not yet set, so no swap occurs. The swap happens on the next tick, and that tick counts toward the delay normally.
- `in_ready` drops the cycle after word 127 is accepted. Never more than 128 writes occur per load.
- Reset mid-load: the load aborts and the partial bank content is ignored. Loading restarts at word 0 of bank 1.

## Structure

- `gif_pkg`: state enum (`LOAD`, `HOLD`), `WADDR_W`=8, `RADDR_W`=10, `WORD_W`=128, `PIX_W`=8, bank-select bit helpers.
- Sub-module `gif_delay_cnt`:
  - contains `dly_cnt`, `first` and the due/underrun decode
  - inputs: `frame_tick`, `clear`
  - outputs: `due`, `underrun_evt`
- The rest (FSM, write counter, read pipe) stays in `gif_frame_ctrl`.

## Test plan

- Initial load: after reset, stream 128 words (word i = i) with `in_valid` held high. Required: `addr_w` runs 0x80..0xFF, `in_ready` drops after word 127, and the first `frame_tick` gives `front_bank`=1 and `frame_count`=1.
- Delay: `FRAME_DELAY`=3, next frame fully loaded. Required: the swap occurs on the 3rd tick after the previous swap, not before.
- Read mapping: `front_bank`=1, `pix_req` with `pix_addr`=0x005. Required: `addr_r`=0x205, `read`=1, and `pix_valid`=1 the next clock with `pix_data`=`dr`.
- Underrun: stall `in_valid` past the delay. Required: `underrun`=1 at the due tick, `front_bank` unchanged, and the swap occurs on the first tick after word 127 is accepted.
- Corner: word 127 accepted in the same cycle as `frame_tick`. Required: no swap that cycle, swap on the next tick. A `pix_req` in a swap cycle reads the old bank.
- Reset mid-load at word 50. Required: all outputs return to reset values, and the next accepted word writes `addr_w`=0x80.
